nibbler_fetch: RTL

NIBBLER_FETCH -- requirements
Module: nibbler_fetch

---
 rtl/nibbler_fetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/nibbler_fetch.sv
// nibbler_fetch: instruction fetch/decode front end for the 4-bit Nibbler core.
// Fetches 1-byte (short) or 2-byte (long, bit 7 set) instructions from a
// combinational program ROM, presents the decoded fields for one EXEC cycle,
// and loads the branch target into the PC when execute asks for a long jump.
module nibbler_fetch (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        stall,
  input  logic        jump_take,
  output logic        instr_valid,
  output logic [3:0]  opcode,
  output logic [3:0]  imm4,
  output logic [11:0] target,
  output logic [11:0] pc_out
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IR_W   = 16;

  typedef enum logic [1:0] {
    S_FETCH1 = 2'd0,
    S_FETCH2 = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_next;
  logic [IR_W-1:0]     r_ir;
  logic [IR_W-1:0]     w_ir_next;
  logic [ADDR_W-1:0]   r_pc_out;
  logic [ADDR_W-1:0]   w_pc_out_next;
  logic [ADDR_W-1:0]   r_target;
  logic [ADDR_W-1:0]   w_target_next;
  logic                r_instr_valid;
  logic                w_instr_valid_next;

  logic [ADDR_W-1:0]   w_pc_inc;
  logic                w_is_long;

  // PC increment wraps naturally at 4096
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_is_long = r_ir[IR_W-1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH1;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next-datapath values; stall freezes everything
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_ir_next          = r_ir;
    w_pc_out_next      = r_pc_out;
    w_target_next      = r_target;
    w_instr_valid_next = r_instr_valid;

    if (!stall) begin
      case (r_state)
        S_FETCH1: begin
          // New instruction: capture opcode byte, clear the operand byte
          w_ir_next     = {rom_data, BYTE_W'(0)};
          w_pc_out_next = r_pc;
          w_pc_next     = w_pc_inc;
          w_target_next = ADDR_W'(0);
          w_state_next  = rom_data[BYTE_W-1] ? S_FETCH2 : S_EXEC;
        end
        S_FETCH2: begin
          w_ir_next     = {r_ir[IR_W-1:BYTE_W], rom_data};
          w_pc_next     = w_pc_inc;
          w_target_next = {r_ir[BYTE_W+3:BYTE_W], rom_data};
          w_state_next  = S_EXEC;
        end
        S_EXEC: begin
          // Only long instructions carry a target worth jumping to
          if (jump_take && w_is_long) begin
            w_pc_next = r_target;
          end
          w_state_next = S_FETCH1;
        end
        default: begin
          w_state_next = S_FETCH1;
        end
      endcase
      w_instr_valid_next = (w_state_next == S_EXEC);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= ADDR_W'(0);
      r_ir          <= IR_W'(0);
      r_pc_out      <= ADDR_W'(0);
      r_target      <= ADDR_W'(0);
      r_instr_valid <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_ir          <= w_ir_next;
      r_pc_out      <= w_pc_out_next;
      r_target      <= w_target_next;
      r_instr_valid <= w_instr_valid_next;
    end
  end

  assign rom_addr    = r_pc;
  assign instr_valid = r_instr_valid;
  assign opcode      = r_ir[IR_W-1:IR_W-4];
  assign imm4        = r_ir[IR_W-5:IR_W-8];
  assign target      = r_target;
  assign pc_out      = r_pc_out;

endmodule
